rv32i_imem_if: RTL and testbench

//  Instruction-memory responder for the fetch stage. Serves word reads on memIfAddr and

---
 rtl/rv32i_imem_if.sv | 206 ++++++++++++++++++++
 tb/tb_rv32i_imem_if.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_imem_if.sv
// rv32i_imem_if: instruction-memory responder for the fetch stage.
// Fetch reads are answered one cycle later through a registered word. A byte-serial
// load port assembles little-endian words into the backing store. Fetch sees NOPs
// while a load is in flight, so reads and writes never share a cycle.
module rv32i_imem_if #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] memIfAddr,
   output logic [31:0] memIfData,
   output logic        addr_err,
   input  logic        ld_start,
   input  logic [29:0] ld_base,
   input  logic [7:0]  ld_byte,
   input  logic        ld_valid,
   input  logic        ld_last,
   output logic        ld_ready,
   output logic        ld_busy,
   output logic        ld_done
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;

   // Load datapath state
   logic [AW-1:0]     waddr_r;
   logic [1:0]        byte_cnt_r;
   logic [31:0]       buf_r;

   // Combinational helpers
   logic              hs_s;
   logic              mem_we_s;
   logic [31:0]       word_s;
   logic              in_range_s;
   logic              ready_s;
   logic              busy_s;
   logic              done_s;

   // Backing store, intentionally left uninitialised by reset
   logic [31:0]       mem_r [DEPTH_WORDS];

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state: start only from IDLE, leave LOAD on the final handshake, DONE lasts one cycle
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ld_start) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (hs_s && ld_last) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_LOAD;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM outputs decoded straight from the state flops so they never glitch
   always_comb begin
      ready_s = 1'b0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            ready_s = 1'b0;
            busy_s  = 1'b0;
            done_s  = 1'b0;
         end
         ST_LOAD: begin
            ready_s = 1'b1;
            busy_s  = 1'b1;
            done_s  = 1'b0;
         end
         ST_DONE: begin
            ready_s = 1'b0;
            busy_s  = 1'b1;
            done_s  = 1'b1;
         end
         default: begin
            ready_s = 1'b0;
            busy_s  = 1'b0;
            done_s  = 1'b0;
         end
      endcase
   end

   assign ld_ready = ready_s;
   assign ld_busy  = busy_s;
   assign ld_done  = done_s;

   assign hs_s = ld_valid && ready_s;

   // Merge the incoming byte into its lane of the word buffer; unfilled lanes stay zero
   always_comb begin
      word_s = buf_r;
      case (byte_cnt_r)
         2'd0:    word_s[7:0]   = ld_byte;
         2'd1:    word_s[15:8]  = ld_byte;
         2'd2:    word_s[23:16] = ld_byte;
         2'd3:    word_s[31:24] = ld_byte;
         default: word_s        = buf_r;
      endcase
   end

   // A word is committed when its fourth byte lands or when the stream ends early;
   // a final byte that also completes the word produces a single write
   always_comb begin
      if (hs_s && ((byte_cnt_r == 2'd3) || ld_last)) begin
         mem_we_s = 1'b1;
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Load datapath: capture base on start, advance byte lane and word address on handshakes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         waddr_r    <= '0;
         byte_cnt_r <= 2'd0;
         buf_r      <= 32'd0;
      end else if ((state_r == ST_IDLE) && ld_start) begin
         waddr_r    <= AW'(ld_base);
         byte_cnt_r <= 2'd0;
         buf_r      <= 32'd0;
      end else if (hs_s) begin
         byte_cnt_r <= byte_cnt_r + 2'd1;
         if (byte_cnt_r == 2'd3) begin
            waddr_r <= waddr_r + AW'(1);
            buf_r   <= 32'd0;
         end else begin
            waddr_r <= waddr_r;
            buf_r   <= word_s;
         end
      end else begin
         waddr_r    <= waddr_r;
         byte_cnt_r <= byte_cnt_r;
         buf_r      <= buf_r;
      end
   end

   // Storage write port; no reset so program contents survive a reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[waddr_r] <= word_s;
      end
   end

   // Full-width range check so high address bits never alias into the array
   always_comb begin
      if ({2'b00, memIfAddr} < 32'(DEPTH_WORDS)) begin
         in_range_s = 1'b1;
      end else begin
         in_range_s = 1'b0;
      end
   end

   // Fetch response register: real data only in IDLE, NOP otherwise
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         memIfData <= NOP_WORD;
         addr_err  <= 1'b0;
      end else if (state_r == ST_IDLE) begin
         if (in_range_s) begin
            memIfData <= mem_r[AW'(memIfAddr)];
            addr_err  <= 1'b0;
         end else begin
            memIfData <= NOP_WORD;
            addr_err  <= 1'b1;
         end
      end else begin
         memIfData <= NOP_WORD;
         addr_err  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rv32i_imem_if.sv
// tb_rv32i_imem_if: scoreboard bench for the instruction-memory responder and its load port.
module tb_rv32i_imem_if;

   localparam int          DEPTH = 16;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic        clk;
   logic        reset;
   logic [29:0] memIfAddr;
   logic [31:0] memIfData;
   logic        addr_err;
   logic        ld_start;
   logic [29:0] ld_base;
   logic [7:0]  ld_byte;
   logic        ld_valid;
   logic        ld_last;
   logic        ld_ready;
   logic        ld_busy;
   logic        ld_done;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb_q [$];
   logic [31:0] model_mem [DEPTH];
   logic [7:0]  stim [8];
   int          n_tests;
   int          n_fail;
   int          hs_cnt;

   rv32i_imem_if #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
      .clk       (clk),
      .reset     (reset),
      .memIfAddr (memIfAddr),
      .memIfData (memIfData),
      .addr_err  (addr_err),
      .ld_start  (ld_start),
      .ld_base   (ld_base),
      .ld_byte   (ld_byte),
      .ld_valid  (ld_valid),
      .ld_last   (ld_last),
      .ld_ready  (ld_ready),
      .ld_busy   (ld_busy),
      .ld_done   (ld_done)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent handshake counter seen at each active edge
   initial hs_cnt = 0;
   always @(posedge clk) begin
      if (ld_valid === 1'b1 && ld_ready === 1'b1) hs_cnt <= hs_cnt + 1;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pop one expected fetch response and compare it with the DUT output
   task automatic sb_check(input string tag);
      exp_t e;
      check_val({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val({tag, "_data"}, memIfData, e.data);
         check_val({tag, "_err"}, {31'd0, addr_err}, {31'd0, e.err});
      end
   endtask

   // Reference assembly of a byte stream into the model memory
   task automatic model_load(input int base, input int n, input bit has_last);
      int          wa;
      int          cnt;
      logic [31:0] w;
      wa  = base % DEPTH;
      cnt = 0;
      w   = 32'd0;
      for (int i = 0; i < n; i++) begin
         w[8*cnt +: 8] = stim[i];
         if (cnt == 3 || (has_last && i == n - 1)) model_mem[wa] = w;
         if (cnt == 3) begin
            wa = (wa + 1) % DEPTH;
            w  = 32'd0;
            cnt = 0;
         end else begin
            cnt++;
         end
      end
   endtask

   task automatic fetch(input logic [29:0] a, input string tag);
      exp_t e;
      memIfAddr = a;
      if (a >= 30'(DEPTH)) begin
         e.data = NOP;
         e.err  = 1'b1;
      end else begin
         e.data = model_mem[a[3:0]];
         e.err  = 1'b0;
      end
      sb_q.push_back(e);
      tick();
      sb_check(tag);
   endtask

   // Drive a load; gaps inserts idle cycles, abort_at>0 resets after that many bytes
   task automatic run_load(input int base, input int n, input bit gaps, input int abort_at,
                           input string tag);
      int   hs0;
      exp_t e;
      hs0      = hs_cnt;
      ld_base  = 30'(base);
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      check_val({tag, "_busy"}, {31'd0, ld_busy}, 32'd1);
      check_val({tag, "_ready"}, {31'd0, ld_ready}, 32'd1);
      for (int i = 0; i < n; i++) begin
         if (abort_at <= 0 || i < abort_at) begin
            if (gaps) begin
               ld_valid = 1'b0;
               repeat ((i % 2 == 1) ? 3 : 1) tick();
            end
            ld_valid  = 1'b1;
            ld_byte   = stim[i];
            ld_last   = (i == n - 1) && (abort_at <= 0);
            memIfAddr = 30'd0;
            e.data = NOP;
            e.err  = 1'b0;
            sb_q.push_back(e);
            tick();
            sb_check({tag, "_mask"});
            check_val({tag, "_done"}, {31'd0, ld_done},
                      (i == n - 1 && abort_at <= 0) ? 32'd1 : 32'd0);
         end
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      if (abort_at > 0) begin
         reset = 1'b0;
         #1;
         check_val({tag, "_abort_busy"}, {31'd0, ld_busy}, 32'd0);
         check_val({tag, "_abort_ready"}, {31'd0, ld_ready}, 32'd0);
         check_val({tag, "_abort_data"}, memIfData, NOP);
         tick();
         reset = 1'b1;
         tick();
         check_val({tag, "_hs"}, 32'(hs_cnt - hs0), 32'(abort_at));
         model_load(base, abort_at, 1'b0);
      end else begin
         check_val({tag, "_ready_done"}, {31'd0, ld_ready}, 32'd0);
         e.data = NOP;
         e.err  = 1'b0;
         sb_q.push_back(e);
         tick();
         sb_check({tag, "_done_mask"});
         check_val({tag, "_done_clr"}, {31'd0, ld_done}, 32'd0);
         check_val({tag, "_busy_clr"}, {31'd0, ld_busy}, 32'd0);
         check_val({tag, "_hs"}, 32'(hs_cnt - hs0), 32'(n));
         model_load(base, n, 1'b1);
      end
   endtask

   task automatic set_t2();
      stim[0] = 8'h13; stim[1] = 8'h05; stim[2] = 8'hA0; stim[3] = 8'h00;
      stim[4] = 8'h93; stim[5] = 8'h05; stim[6] = 8'h10; stim[7] = 8'h00;
   endtask

   initial begin
      int hs0;
      n_tests   = 0;
      n_fail    = 0;
      reset     = 1'b0;
      memIfAddr = 30'd0;
      ld_start  = 1'b0;
      ld_base   = 30'd0;
      ld_byte   = 8'd0;
      ld_valid  = 1'b0;
      ld_last   = 1'b0;

      // T1: reset state with clocks running
      repeat (3) tick();
      check_val("t1_data", memIfData, NOP);
      check_val("t1_err", {31'd0, addr_err}, 32'd0);
      check_val("t1_ready", {31'd0, ld_ready}, 32'd0);
      check_val("t1_busy", {31'd0, ld_busy}, 32'd0);
      check_val("t1_done", {31'd0, ld_done}, 32'd0);
      reset = 1'b1;
      tick();

      // T2: two-word program at base 0
      set_t2();
      run_load(0, 8, 1'b0, 0, "t2");
      fetch(30'd0, "t2_w0");
      check_val("t2_w0_lit", memIfData, 32'h00A00513);
      fetch(30'd1, "t2_w1");
      check_val("t2_w1_lit", memIfData, 32'h00100593);

      // Bytes offered in IDLE are not consumed
      hs0      = hs_cnt;
      ld_valid = 1'b1;
      ld_byte  = 8'hFF;
      repeat (2) tick();
      check_val("idle_ready", {31'd0, ld_ready}, 32'd0);
      check_val("idle_hs", 32'(hs_cnt - hs0), 32'd0);
      ld_valid = 1'b0;

      // T3: partial final word, upper byte zero-filled
      stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC;
      run_load(4, 3, 1'b0, 0, "t3");
      fetch(30'd4, "t3_w4");
      check_val("t3_w4_lit", memIfData, 32'h00CCBBAA);

      // T4: same stream as T2 with valid gaps
      set_t2();
      run_load(0, 8, 1'b1, 0, "t4");
      fetch(30'd0, "t4_w0");
      fetch(30'd1, "t4_w1");

      // T5: out-of-range fetch and recovery, no aliasing of high bits
      fetch(30'(DEPTH), "t5_oor");
      fetch(30'd0, "t5_inr");
      fetch(30'h3FFF_FFF4, "t5_alias");
      fetch(30'd4, "t5_inr2");

      // T6: write address wraps from the last word to word 0
      for (int i = 0; i < 8; i++) stim[i] = 8'(8'h11 + i);
      run_load(DEPTH - 1, 8, 1'b0, 0, "t6");
      fetch(30'(DEPTH - 1), "t6_wlast");
      check_val("t6_wlast_lit", memIfData, 32'h14131211);
      fetch(30'd0, "t6_w0");
      check_val("t6_w0_lit", memIfData, 32'h18171615);

      // Reset after six bytes: word 0 rewritten, word 1 keeps its old contents
      set_t2();
      run_load(0, 8, 1'b0, 6, "rst");
      fetch(30'd0, "rst_w0");
      check_val("rst_w0_lit", memIfData, 32'h00A00513);
      fetch(30'd1, "rst_w1");
      check_val("rst_w1_lit", memIfData, 32'h00100593);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
